// File: rtl/btb_alloc_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : btb_alloc_ctrl
//  Description : Allocation and prediction controller for a 4-entry branch
//                target buffer. Performs a combinational fetch-PC lookup
//                against an external PC array. Resolved branches update 2-bit
//                saturating counters, or allocate a new entry. Victims are
//                chosen from invalid entries first, then round-robin.
//  Revision    : 1.0 - initial release
// ============================================================================
module btb_alloc_ctrl #(
  parameter int width = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  // fetch-side lookup
  input  logic [width-1:0] fetch_pc,
  output logic             pred_hit,
  output logic [1:0]       pred_index,
  output logic             pred_taken,
  // resolved-branch request from execute
  input  logic             res_valid,
  output logic             res_ready,
  input  logic [width-1:0] res_pc,
  input  logic             res_taken,
  // external PC array readback and write port
  input  logic [width-1:0] arr_pc0,
  input  logic [width-1:0] arr_pc1,
  input  logic [width-1:0] arr_pc2,
  input  logic [width-1:0] arr_pc3,
  output logic             arr_write,
  output logic [1:0]       arr_index,
  output logic [width-1:0] arr_datain
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOOKUP = 2'd1,
    ST_ALLOC  = 2'd2
  } state_e;

  localparam logic [1:0] c_ctr_reset = 2'b01;
  localparam logic [1:0] c_ctr_alloc = 2'b10;

  state_e            state_q, state_d;
  logic [3:0]        valid_q, valid_d;
  logic [3:0][1:0]   ctr_q, ctr_d;
  logic [1:0]        rr_q, rr_d;
  logic [width-1:0]  cap_pc_q, cap_pc_d;
  logic              cap_taken_q, cap_taken_d;

  logic [width-1:0]  w_arr_pc [4];
  logic [1:0]        w_victim;
  logic              w_victim_is_rr;
  logic [3:0]        w_fetch_valid;
  logic [3:0]        w_fetch_match;
  logic [3:0]        w_res_match;
  logic              w_res_hit;
  logic [1:0]        w_res_index;

  assign w_arr_pc[0] = arr_pc0;
  assign w_arr_pc[1] = arr_pc1;
  assign w_arr_pc[2] = arr_pc2;
  assign w_arr_pc[3] = arr_pc3;

  // Two-bit saturating counter step.
  function automatic logic [1:0] f_sat_step(input logic [1:0] c, input logic up);
    logic [1:0] r;
    r = c;
    if (up) begin
      if (c != 2'b11) r = c + 2'd1;
    end else begin
      if (c != 2'b00) r = c - 2'd1;
    end
    return r;
  endfunction

  // Victim selection: lowest invalid entry, else the round-robin pointer.
  always_comb begin
    w_victim       = rr_q;
    w_victim_is_rr = 1'b1;
    for (int i = 3; i >= 0; i--) begin
      if (!valid_q[i]) begin
        w_victim       = 2'(i);
        w_victim_is_rr = 1'b0;
      end
    end
  end

  // Hide the entry being overwritten from fetch until the write has landed.
  always_comb begin
    w_fetch_valid = valid_q;
    if (state_q == ST_ALLOC) w_fetch_valid[w_victim] = 1'b0;
  end

  // Fetch lookup; valid gates every compare so unwritten array words cannot leak X.
  always_comb begin
    pred_index = 2'd0;
    for (int i = 0; i < 4; i++) begin
      w_fetch_match[i] = w_fetch_valid[i] & (w_arr_pc[i] == fetch_pc);
    end
    for (int i = 3; i >= 0; i--) begin
      if (w_fetch_match[i]) pred_index = 2'(i);
    end
    pred_hit   = |w_fetch_match;
    pred_taken = pred_hit & ctr_q[pred_index][1];
  end

  // Resolve-side lookup of the captured PC against the valid entries.
  always_comb begin
    w_res_index = 2'd0;
    for (int i = 0; i < 4; i++) begin
      w_res_match[i] = valid_q[i] & (w_arr_pc[i] == cap_pc_q);
    end
    for (int i = 3; i >= 0; i--) begin
      if (w_res_match[i]) w_res_index = 2'(i);
    end
    w_res_hit = |w_res_match;
  end

  // Next-state, per-entry state updates and array write port.
  always_comb begin
    state_d     = state_q;
    valid_d     = valid_q;
    ctr_d       = ctr_q;
    rr_d        = rr_q;
    cap_pc_d    = cap_pc_q;
    cap_taken_d = cap_taken_q;
    res_ready   = 1'b0;
    arr_write   = 1'b0;
    arr_index   = 2'd0;
    arr_datain  = '0;

    case (state_q)
      ST_IDLE: begin
        res_ready = 1'b1;
        if (res_valid) begin
          cap_pc_d    = res_pc;
          cap_taken_d = res_taken;
          state_d     = ST_LOOKUP;
        end
      end

      ST_LOOKUP: begin
        if (w_res_hit) begin
          ctr_d[w_res_index] = f_sat_step(ctr_q[w_res_index], cap_taken_q);
          state_d            = ST_IDLE;
        end else if (cap_taken_q) begin
          state_d = ST_ALLOC;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_ALLOC: begin
        arr_write         = 1'b1;
        arr_index         = w_victim;
        arr_datain        = cap_pc_q;
        valid_d[w_victim] = 1'b1;
        ctr_d[w_victim]   = c_ctr_alloc;
        // Only a replacement of a valid entry moves the round-robin pointer.
        if (w_victim_is_rr) rr_d = rr_q + 2'd1;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers; reset wins over any in-flight allocation.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      valid_q     <= 4'b0000;
      ctr_q       <= {4{c_ctr_reset}};
      rr_q        <= 2'd0;
      cap_pc_q    <= '0;
      cap_taken_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      valid_q     <= valid_d;
      ctr_q       <= ctr_d;
      rr_q        <= rr_d;
      cap_pc_q    <= cap_pc_d;
      cap_taken_q <= cap_taken_d;
    end
  end

endmodule
`default_nettype wire
